// File: rtl/eth_dma_mem_responder.sv
// AXI4 INCR-only memory responder for the Ethernet DMA master port.
// Independent write (AW/W/B) and read (AR/R) FSMs share one word-addressed RAM.
module eth_dma_mem_responder #(
   parameter int dma_addr_bits  = 64,
   parameter int dma_word_bits  = 64,
   parameter int mem_words_log2 = 12
) (
   input  logic                       clock,
   input  logic                       async_resetn,
   input  logic [dma_addr_bits-1:0]   s_axi_awaddr,
   input  logic [7:0]                 s_axi_awlen,
   input  logic                       s_axi_awvalid,
   output logic                       s_axi_awready,
   input  logic [dma_word_bits-1:0]   s_axi_wdata,
   input  logic [dma_word_bits/8-1:0] s_axi_wstrb,
   input  logic                       s_axi_wlast,
   input  logic                       s_axi_wvalid,
   output logic                       s_axi_wready,
   output logic [1:0]                 s_axi_bresp,
   output logic                       s_axi_bvalid,
   input  logic                       s_axi_bready,
   input  logic [dma_addr_bits-1:0]   s_axi_araddr,
   input  logic [7:0]                 s_axi_arlen,
   input  logic                       s_axi_arvalid,
   output logic                       s_axi_arready,
   output logic [dma_word_bits-1:0]   s_axi_rdata,
   output logic [1:0]                 s_axi_rresp,
   output logic                       s_axi_rlast,
   output logic                       s_axi_rvalid,
   input  logic                       s_axi_rready,
   output logic [15:0]                err_count
);
   localparam int STRB_W = dma_word_bits / 8;
   localparam int SHIFT  = $clog2(STRB_W);
   localparam int AW     = dma_addr_bits;
   localparam int MW     = mem_words_log2;
   localparam logic [AW-1:0] IDX_ONE = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [AW-1:0] MEM_TOP = IDX_ONE << MW;

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
   typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

   // Range test on the full-width word index so high address bits are never lost.
   function automatic logic in_range(input logic [AW-1:0] idx);
      return (idx < MEM_TOP);
   endfunction

   logic [dma_word_bits-1:0] mem [0:(2**MW)-1];

   w_state_t                 w_state_q, w_state_d;
   logic [AW-1:0]            w_idx_q, w_idx_d;
   logic [7:0]               w_cnt_q, w_cnt_d;
   logic                     w_err_q, w_err_d;
   logic                     mem_we_s;

   r_state_t                 r_state_q, r_state_d;
   logic [AW-1:0]            r_idx_q, r_idx_d;
   logic [7:0]               r_cnt_q, r_cnt_d;
   logic                     r_err_q, r_err_d;
   logic [dma_word_bits-1:0] rdata_q, rdata_d;
   logic [1:0]               rresp_q, rresp_d;
   logic                     rlast_q, rlast_d;
   logic                     ld_en_s;
   logic                     r_err_evt_s;

   logic                     b_err_evt_s;
   logic [16:0]              err_sum_s;
   logic [15:0]              err_count_q, err_count_d;

   always_comb begin
      w_state_d = w_state_q;
      w_idx_d   = w_idx_q;
      w_cnt_d   = w_cnt_q;
      w_err_d   = w_err_q;
      mem_we_s  = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            if (s_axi_awvalid) begin
               w_idx_d   = s_axi_awaddr >> SHIFT;
               w_cnt_d   = s_axi_awlen;
               w_err_d   = 1'b0;
               w_state_d = W_DATA;
            end else begin
               w_state_d = W_IDLE;
            end
         end
         W_DATA: begin
            if (s_axi_wvalid) begin
               mem_we_s = in_range(w_idx_q);
               w_err_d  = w_err_q | ~in_range(w_idx_q) | (s_axi_wlast != (w_cnt_q == 8'd0));
               w_idx_d  = w_idx_q + IDX_ONE;
               if (w_cnt_q == 8'd0) begin
                  w_state_d = W_RESP;
               end else begin
                  w_cnt_d = w_cnt_q - 8'd1;
               end
            end else begin
               w_state_d = W_DATA;
            end
         end
         W_RESP: begin
            if (s_axi_bready) begin
               w_state_d = W_IDLE;
            end else begin
               w_state_d = W_RESP;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Read data is captured into rdata_q, so a same-cycle write to the word is seen next beat only.
   always_comb begin
      r_state_d   = r_state_q;
      r_idx_d     = r_idx_q;
      r_cnt_d     = r_cnt_q;
      r_err_d     = r_err_q;
      rdata_d     = rdata_q;
      rresp_d     = rresp_q;
      rlast_d     = rlast_q;
      ld_en_s     = 1'b0;
      r_err_evt_s = 1'b0;
      case (r_state_q)
         R_IDLE: begin
            if (s_axi_arvalid) begin
               r_idx_d   = s_axi_araddr >> SHIFT;
               r_cnt_d   = s_axi_arlen;
               r_err_d   = 1'b0;
               ld_en_s   = 1'b1;
               r_state_d = R_DATA;
            end else begin
               r_state_d = R_IDLE;
            end
         end
         R_DATA: begin
            if (s_axi_rready) begin
               r_err_d = r_err_q | rresp_q[1];
               if (r_cnt_q == 8'd0) begin
                  r_err_evt_s = r_err_q | rresp_q[1];
                  r_state_d   = R_IDLE;
                  rdata_d     = {dma_word_bits{1'b0}};
                  rresp_d     = 2'b00;
                  rlast_d     = 1'b0;
               end else begin
                  r_idx_d = r_idx_q + IDX_ONE;
                  r_cnt_d = r_cnt_q - 8'd1;
                  ld_en_s = 1'b1;
               end
            end else begin
               r_state_d = R_DATA;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
      if (ld_en_s) begin
         rdata_d = in_range(r_idx_d) ? mem[r_idx_d[MW-1:0]] : {dma_word_bits{1'b0}};
         rresp_d = in_range(r_idx_d) ? 2'b00 : 2'b10;
         rlast_d = (r_cnt_d == 8'd0);
      end else begin
         rlast_d = rlast_d;
      end
   end

   always_comb begin
      b_err_evt_s = s_axi_bvalid & s_axi_bready & w_err_q;
      err_sum_s   = {1'b0, err_count_q} + {16'd0, b_err_evt_s} + {16'd0, r_err_evt_s};
      err_count_d = err_sum_s[16] ? 16'hFFFF : err_sum_s[15:0];
   end

   // RAM write port carries no reset: contents survive async_resetn.
   always_ff @(posedge clock) begin
      if (mem_we_s) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (s_axi_wstrb[b]) begin
               mem[w_idx_q[MW-1:0]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
         end
      end
   end

   always_ff @(posedge clock or negedge async_resetn) begin
      if (!async_resetn) begin
         w_state_q   <= W_IDLE;
         w_idx_q     <= {AW{1'b0}};
         w_cnt_q     <= 8'd0;
         w_err_q     <= 1'b0;
         r_state_q   <= R_IDLE;
         r_idx_q     <= {AW{1'b0}};
         r_cnt_q     <= 8'd0;
         r_err_q     <= 1'b0;
         rdata_q     <= {dma_word_bits{1'b0}};
         rresp_q     <= 2'b00;
         rlast_q     <= 1'b0;
         err_count_q <= 16'd0;
      end else begin
         w_state_q   <= w_state_d;
         w_idx_q     <= w_idx_d;
         w_cnt_q     <= w_cnt_d;
         w_err_q     <= w_err_d;
         r_state_q   <= r_state_d;
         r_idx_q     <= r_idx_d;
         r_cnt_q     <= r_cnt_d;
         r_err_q     <= r_err_d;
         rdata_q     <= rdata_d;
         rresp_q     <= rresp_d;
         rlast_q     <= rlast_d;
         err_count_q <= err_count_d;
      end
   end

   assign s_axi_awready = (w_state_q == W_IDLE);
   assign s_axi_wready  = (w_state_q == W_DATA);
   assign s_axi_bvalid  = (w_state_q == W_RESP);
   assign s_axi_bresp   = s_axi_bvalid ? {w_err_q, 1'b0} : 2'b00;
   assign s_axi_arready = (r_state_q == R_IDLE);
   assign s_axi_rvalid  = (r_state_q == R_DATA);
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = rresp_q;
   assign s_axi_rlast   = rlast_q;
   assign err_count     = err_count_q;
endmodule

// File: tb/tb_eth_dma_mem_responder.sv
// Scoreboard bench for eth_dma_mem_responder: a word-array memory model predicts
// B/R responses at issue time; a negedge monitor pops and compares on handshakes.
module tb_eth_dma_mem_responder;
   logic        clock = 1'b0;
   logic        async_resetn;
   logic [63:0] s_axi_awaddr, s_axi_araddr, s_axi_wdata, s_axi_rdata;
   logic [7:0]  s_axi_awlen, s_axi_arlen, s_axi_wstrb;
   logic        s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
   logic [1:0]  s_axi_bresp, s_axi_rresp;
   logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
   logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;
   logic [15:0] err_count;

   always #5 clock = ~clock;

   eth_dma_mem_responder dut (
      .clock(clock), .async_resetn(async_resetn),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awvalid(s_axi_awvalid),
      .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
      .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
      .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
      .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arvalid(s_axi_arvalid),
      .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
      .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
      .err_count(err_count)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   int          b_seen = 0;
   int          r_seen = 0;
   int          exp_err = 0;
   bit          bp = 1'b0;
   logic [63:0] model [0:4095];
   logic [63:0] wdat [0:255];
   logic [7:0]  wstb [0:255];
   logic [66:0] rq [$];
   logic [1:0]  bq [$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic rdy(input int which);
      case (which)
         0:       return s_axi_awready;
         1:       return s_axi_wready;
         default: return s_axi_arready;
      endcase
   endfunction

   // Inputs are already driven; wait for ready, then step past the handshake edge.
   task automatic hs(input int which, input string name);
      int   t = 0;
      logic got = 1'b0;
      while (!got && t < 200) begin
         @(negedge clock);
         got = rdy(which);
         t++;
      end
      if (!got) begin
         n_cmp++; n_bad++;
         $display("FAIL %s_timeout: no ready after %0d cycles", name, t);
      end
      @(posedge clock); #1;
   endtask

   task automatic wait_seen(input int which, input int tgt);
      int t = 0;
      while (((which == 0) ? b_seen : r_seen) < tgt && t < 5000) begin
         @(negedge clock);
         t++;
      end
      if (((which == 0) ? b_seen : r_seen) < tgt) begin
         n_cmp++; n_bad++;
         $display("FAIL %s_timeout: response never arrived", (which == 0) ? "b" : "r");
      end
      @(posedge clock); #1;
   endtask

   task automatic write_burst(input logic [63:0] addr, input int len, input int wlast_at, input bit gaps);
      longint unsigned base = addr >> 3;
      bit err = 1'b0;
      int tgt = b_seen + 1;
      for (int i = 0; i <= len; i++) begin
         if (base + longint'(i) < 4096) begin
            for (int b = 0; b < 8; b++)
               if (wstb[i][b]) model[base + longint'(i)][b*8 +: 8] = wdat[i][b*8 +: 8];
         end else begin
            err = 1'b1;
         end
      end
      if (wlast_at >= 0 && wlast_at != len) err = 1'b1;
      bq.push_back(err ? 2'b10 : 2'b00);
      if (err && exp_err < 65535) exp_err++;
      s_axi_awaddr = addr; s_axi_awlen = len[7:0]; s_axi_awvalid = 1'b1;
      hs(0, "aw");
      s_axi_awvalid = 1'b0;
      for (int i = 0; i <= len; i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
         s_axi_wdata  = wdat[i];
         s_axi_wstrb  = wstb[i];
         s_axi_wlast  = (wlast_at < 0) ? (i == len) : (i == wlast_at);
         s_axi_wvalid = 1'b1;
         hs(1, "w");
         s_axi_wvalid = 1'b0;
         s_axi_wlast  = 1'b0;
      end
      wait_seen(0, tgt);
      check("err_count_wr", err_count, exp_err);
   endtask

   task automatic read_burst(input logic [63:0] addr, input int len);
      longint unsigned base = addr >> 3;
      longint unsigned idx;
      bit err = 1'b0;
      int tgt = r_seen + len + 1;
      for (int i = 0; i <= len; i++) begin
         idx = base + longint'(i);
         if (idx < 4096) rq.push_back({model[idx], 2'b00, (i == len)});
         else begin
            rq.push_back({64'd0, 2'b10, (i == len)});
            err = 1'b1;
         end
      end
      if (err && exp_err < 65535) exp_err++;
      s_axi_araddr = addr; s_axi_arlen = len[7:0]; s_axi_arvalid = 1'b1;
      hs(2, "ar");
      s_axi_arvalid = 1'b0;
      wait_seen(1, tgt);
      check("err_count_rd", err_count, exp_err);
   endtask

   // Monitor: compare every B/R handshake against the queues and hold-stability while stalled.
   initial begin
      bit          stall_pend = 1'b0;
      logic [66:0] held, cur;
      forever begin
         @(negedge clock);
         if (!async_resetn) begin
            stall_pend = 1'b0;
         end else begin
            if (s_axi_bvalid && s_axi_bready) begin
               if (bq.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL b_extra: got bresp %0h expected none", s_axi_bresp);
               end else check("bresp", s_axi_bresp, bq.pop_front());
               b_seen++;
            end
            if (s_axi_rvalid) begin
               cur = {s_axi_rdata, s_axi_rresp, s_axi_rlast};
               if (stall_pend) check("r_stable", cur, held);
               if (s_axi_rready) begin
                  if (rq.size() == 0) begin
                     n_cmp++; n_bad++;
                     $display("FAIL r_extra: got beat %0h expected none", cur);
                  end else check("rbeat", cur, rq.pop_front());
                  r_seen++;
                  stall_pend = 1'b0;
               end else begin
                  stall_pend = 1'b1;
                  held = cur;
               end
            end else begin
               stall_pend = 1'b0;
            end
         end
      end
   end

   initial begin
      s_axi_bready = 1'b1;
      s_axi_rready = 1'b1;
      forever begin
         @(posedge clock); #1;
         s_axi_bready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
         s_axi_rready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
   end

   initial begin
      logic [63:0] a;
      int          len, base, rs;
      async_resetn = 1'b0;
      s_axi_awaddr = 64'd0; s_axi_awlen = 8'd0; s_axi_awvalid = 1'b0;
      s_axi_wdata = 64'd0; s_axi_wstrb = 8'd0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
      s_axi_araddr = 64'd0; s_axi_arlen = 8'd0; s_axi_arvalid = 1'b0;
      for (int i = 0; i < 4096; i++) model[i] = 64'd0;
      repeat (2) @(posedge clock);
      #2;
      check("reset_ctrl", {s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid,
                           s_axi_rlast, s_axi_bresp, s_axi_rresp}, 10'b11_0000_0000);
      check("reset_rdata", s_axi_rdata, 64'd0);
      check("reset_err", err_count, 16'd0);
      @(posedge clock); #1;
      async_resetn = 1'b1;
      @(posedge clock); #1;

      // Initialise the regions that reads will touch.
      for (int i = 0; i < 128; i++) begin wdat[i] = {$urandom, $urandom}; wstb[i] = 8'hFF; end
      write_burst(64'h0, 127, -1, 1'b0);
      for (int i = 0; i < 32; i++) begin wdat[i] = {$urandom, $urandom}; wstb[i] = 8'hFF; end
      write_burst(64'(4064) << 3, 31, -1, 1'b0);

      wdat[0] = 64'hA5A5_0000_1234_5678; wstb[0] = 8'hFF;
      write_burst(64'h10, 0, -1, 1'b0);
      read_burst(64'h10, 0);
      check("single_err", err_count, 16'd0);

      for (int i = 0; i < 16; i++) begin wdat[i] = 64'(i); wstb[i] = (i == 3) ? 8'h0F : 8'hFF; end
      write_burst(64'h100, 15, -1, 1'b0);
      read_burst(64'h100, 15);

      for (int i = 0; i < 4; i++) begin wdat[i] = {$urandom, $urandom}; wstb[i] = 8'hFF; end
      write_burst(64'h7FF0, 3, -1, 1'b0);
      check("top_wr_err", err_count, 16'd1);
      read_burst(64'h7FF0, 3);
      check("top_rd_err", err_count, 16'd2);

      for (int i = 0; i < 5; i++) begin wdat[i] = {$urandom, $urandom}; wstb[i] = 8'hFF; end
      write_burst(64'h200, 4, 2, 1'b0);
      read_burst(64'h200, 4);

      bp = 1'b1;
      for (int n = 0; n < 200; n++) begin
         len = $urandom_range(0, 15);
         if ($urandom_range(0, 3) == 0) base = 4064 + $urandom_range(0, 31);
         else base = $urandom_range(0, 127 - len);
         a = (64'(base) << 3) | 64'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 0) begin
            for (int i = 0; i <= len; i++) begin
               wdat[i] = {$urandom, $urandom};
               wstb[i] = 8'($urandom_range(0, 255));
            end
            write_burst(a, len, -1, 1'b1);
         end else begin
            read_burst(a, len);
         end
      end

      // Abort a read burst with reset partway through.
      bp = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      rs = r_seen;
      read_burst_abort: begin
         for (int i = 0; i < 8; i++) rq.push_back({model[40 + i], 2'b00, (i == 7)});
         s_axi_araddr = 64'h140; s_axi_arlen = 8'd7; s_axi_arvalid = 1'b1;
         hs(2, "ar_abort");
         s_axi_arvalid = 1'b0;
         wait_seen(1, rs + 4);
      end
      #1;
      async_resetn = 1'b0;
      #1;
      check("abort_rvalid", s_axi_rvalid, 1'b0);
      rq.delete();
      bq.delete();
      exp_err = 0;
      repeat (2) @(posedge clock);
      #2;
      async_resetn = 1'b1;
      @(negedge clock);
      check("abort_ready", {s_axi_arready, s_axi_awready, s_axi_rvalid}, 3'b110);
      check("abort_err", err_count, 16'd0);
      @(posedge clock); #1;
      read_burst(64'h140, 7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
